// File: rtl/rom_fetch_arb.sv
// SDRAM arbiter for ROM fetch and ioctl download on a single toggle-handshake port.
// Optional per-requester one-entry read tag cache: define ROM_ARB_CACHE_EN.
module rom_fetch_arb #(
   parameter int             AW      = 23,
   parameter logic [AW-1:0]  BG_BASE = 'h8000,
   parameter logic [AW-1:0]  SP_BASE = 'h5000
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          dl_wr,
   input  logic [24:0]   dl_addr,
   input  logic [7:0]    dl_dout,
   output logic          dl_ovf,
   input  logic          cpu_rd,
   input  logic [15:0]   cpu_addr,
   output logic [7:0]    cpu_q,
   output logic          cpu_valid,
   input  logic          bg_rd,
   input  logic [13:0]   bg_addr,
   output logic [7:0]    bg_q,
   output logic          bg_valid,
   input  logic          sp_rd,
   input  logic [13:0]   sp_addr,
   output logic [31:0]   sp_q,
   output logic          sp_valid,
   output logic          mem_req,
   input  logic          mem_ack,
   output logic [AW-1:0] mem_a,
   output logic          mem_we,
   output logic [1:0]    mem_ds,
   output logic [15:0]   mem_d,
   input  logic [15:0]   mem_q
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_SPHI  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   localparam logic [1:0] SRC_DL  = 2'd0;
   localparam logic [1:0] SRC_SP  = 2'd1;
   localparam logic [1:0] SRC_BG  = 2'd2;
   localparam logic [1:0] SRC_CPU = 2'd3;

   function automatic logic [AW-1:0] cpu_word(input logic [15:0] a);
      return AW'(a[15:1]);
   endfunction

   function automatic logic [AW-1:0] bg_word(input logic [13:0] a);
      return BG_BASE + AW'(a[13:1]);
   endfunction

   function automatic logic [AW-1:0] sp_word(input logic [13:0] a, input logic hi);
      return SP_BASE + (AW'(a) << 1) + AW'(hi);
   endfunction

   function automatic logic [7:0] byte_sel(input logic [15:0] w, input logic hi);
      return hi ? w[15:8] : w[7:0];
   endfunction

   logic          cpu_rd_p0, bg_rd_p0, sp_rd_p0, dl_wr_p0;
   logic [15:0]   cpu_addr_p0;
   logic [13:0]   bg_addr_p0, sp_addr_p0;
   logic [23:0]   dl_addr_p0;
   logic [7:0]    dl_dout_p0;

   logic          cpu_pend, bg_pend, sp_pend, dl_full;
   logic [15:0]   cpu_paddr;
   logic [13:0]   bg_paddr, sp_paddr;
   logic [23:0]   dl_baddr;
   logic [7:0]    dl_bdata;

   logic [1:0]    state, cur_src;
   logic          cur_lsb;
   logic [13:0]   cur_sp_addr;

   logic          ack_match, in_idle, dl_go, sp_go, bg_go, cpu_go, dl_accept;
   logic          cpu_hit, bg_hit, sp_hit;
   logic          dl_addr_unused;

   assign dl_addr_unused = dl_addr[24];
   assign ack_match = (mem_ack == mem_req);
   assign in_idle   = (state == S_IDLE);
   assign dl_go     = in_idle && dl_full;
   assign sp_go     = in_idle && !dl_full && sp_pend;
   assign bg_go     = in_idle && !dl_full && !sp_pend && bg_pend;
   assign cpu_go    = in_idle && !dl_full && !sp_pend && !bg_pend && cpu_pend;
   // A byte arriving on the same edge the buffer drains takes the freed slot.
   assign dl_accept = dl_wr_p0 && (!dl_full || dl_go);

`ifdef ROM_ARB_CACHE_EN
   logic          busy, cur_fill_ok;
   logic [AW-1:0] cur_word;
   logic          cpu_tag_v, bg_tag_v, sp_tag_v;
   logic [AW-1:0] cpu_tag_a, bg_tag_a, sp_tag_a;
   logic [15:0]   cpu_tag_d, bg_tag_d;
   logic [31:0]   sp_tag_d;

   // Hits are only taken when the requester is otherwise quiet, so a tag
   // answer never collides with an SDRAM completion for the same port.
   assign busy    = (state == S_WAIT) || (state == S_SPHI);
   assign cpu_hit = cpu_rd_p0 && cpu_tag_v && (cpu_tag_a == cpu_word(cpu_addr_p0)) &&
                    !cpu_pend && !(busy && cur_src == SRC_CPU);
   assign bg_hit  = bg_rd_p0 && bg_tag_v && (bg_tag_a == bg_word(bg_addr_p0)) &&
                    !bg_pend && !(busy && cur_src == SRC_BG);
   assign sp_hit  = sp_rd_p0 && sp_tag_v && (sp_tag_a == sp_word(sp_addr_p0, 1'b0)) &&
                    !sp_pend && !(busy && cur_src == SRC_SP);
`else
   assign cpu_hit = 1'b0;
   assign bg_hit  = 1'b0;
   assign sp_hit  = 1'b0;
`endif

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cpu_rd_p0 <= 1'b0;
         bg_rd_p0  <= 1'b0;
         sp_rd_p0  <= 1'b0;
         dl_wr_p0  <= 1'b0;
         cpu_pend  <= 1'b0;
         bg_pend   <= 1'b0;
         sp_pend   <= 1'b0;
         dl_full   <= 1'b0;
         dl_ovf    <= 1'b0;
         cpu_valid <= 1'b0;
         bg_valid  <= 1'b0;
         sp_valid  <= 1'b0;
         cpu_q     <= '0;
         bg_q      <= '0;
         sp_q      <= '0;
         mem_a     <= '0;
         mem_we    <= 1'b0;
         mem_ds    <= '0;
         mem_d     <= '0;
         cur_src   <= SRC_DL;
         state     <= ack_match ? S_IDLE : S_DRAIN;
`ifdef ROM_ARB_CACHE_EN
         cpu_tag_v   <= 1'b0;
         bg_tag_v    <= 1'b0;
         sp_tag_v    <= 1'b0;
         cur_fill_ok <= 1'b0;
`endif
      end else begin
         // p0: register strobes and addresses
         cpu_rd_p0   <= cpu_rd;
         cpu_addr_p0 <= cpu_addr;
         bg_rd_p0    <= bg_rd;
         bg_addr_p0  <= bg_addr;
         sp_rd_p0    <= sp_rd;
         sp_addr_p0  <= sp_addr;
         dl_wr_p0    <= dl_wr;
         dl_addr_p0  <= dl_addr[23:0];
         dl_dout_p0  <= dl_dout;

         cpu_valid <= 1'b0;
         bg_valid  <= 1'b0;
         sp_valid  <= 1'b0;

         // p1: pending flags, latest strobe overwrites the latched address
         if (cpu_rd_p0 && !cpu_hit) begin
            cpu_pend  <= 1'b1;
            cpu_paddr <= cpu_addr_p0;
         end else if (cpu_go) cpu_pend <= 1'b0;
         if (bg_rd_p0 && !bg_hit) begin
            bg_pend  <= 1'b1;
            bg_paddr <= bg_addr_p0;
         end else if (bg_go) bg_pend <= 1'b0;
         if (sp_rd_p0 && !sp_hit) begin
            sp_pend  <= 1'b1;
            sp_paddr <= sp_addr_p0;
         end else if (sp_go) sp_pend <= 1'b0;

         if (dl_go) dl_full <= 1'b0;
         if (dl_wr_p0) begin
            if (dl_accept) begin
               dl_full  <= 1'b1;
               dl_baddr <= dl_addr_p0;
               dl_bdata <= dl_dout_p0;
            end else dl_ovf <= 1'b1;
         end

         // p2: SDRAM sequencer
         case (state)
            S_IDLE: begin
               if (dl_go) begin
                  mem_a   <= AW'(dl_baddr[23:1]);
                  mem_ds  <= {dl_baddr[0], ~dl_baddr[0]};
                  mem_d   <= {dl_bdata, dl_bdata};
                  mem_we  <= 1'b1;
                  cur_src <= SRC_DL;
               end else if (sp_go) begin
                  mem_a       <= sp_word(sp_paddr, 1'b0);
                  cur_sp_addr <= sp_paddr;
                  cur_src     <= SRC_SP;
`ifdef ROM_ARB_CACHE_EN
                  cur_word    <= sp_word(sp_paddr, 1'b0);
`endif
               end else if (bg_go) begin
                  mem_a   <= bg_word(bg_paddr);
                  cur_lsb <= bg_paddr[0];
                  cur_src <= SRC_BG;
`ifdef ROM_ARB_CACHE_EN
                  cur_word <= bg_word(bg_paddr);
`endif
               end else if (cpu_go) begin
                  mem_a   <= cpu_word(cpu_paddr);
                  cur_lsb <= cpu_paddr[0];
                  cur_src <= SRC_CPU;
`ifdef ROM_ARB_CACHE_EN
                  cur_word <= cpu_word(cpu_paddr);
`endif
               end
               if (sp_go || bg_go || cpu_go) begin
                  mem_we <= 1'b0;
                  mem_ds <= 2'b11;
               end
               if (dl_go || sp_go || bg_go || cpu_go) begin
                  mem_req <= ~mem_req;
                  state   <= S_WAIT;
`ifdef ROM_ARB_CACHE_EN
                  cur_fill_ok <= 1'b1;
`endif
               end
            end
            S_WAIT: begin
               if (ack_match) begin
                  state <= S_IDLE;
                  case (cur_src)
                     SRC_CPU: begin
                        cpu_q     <= byte_sel(mem_q, cur_lsb);
                        cpu_valid <= 1'b1;
`ifdef ROM_ARB_CACHE_EN
                        if (cur_fill_ok) begin
                           cpu_tag_v <= 1'b1;
                           cpu_tag_a <= cur_word;
                           cpu_tag_d <= mem_q;
                        end
`endif
                     end
                     SRC_BG: begin
                        bg_q     <= byte_sel(mem_q, cur_lsb);
                        bg_valid <= 1'b1;
`ifdef ROM_ARB_CACHE_EN
                        if (cur_fill_ok) begin
                           bg_tag_v <= 1'b1;
                           bg_tag_a <= cur_word;
                           bg_tag_d <= mem_q;
                        end
`endif
                     end
                     SRC_SP: begin
                        sp_q[15:0] <= mem_q;
                        mem_a      <= sp_word(cur_sp_addr, 1'b1);
                        mem_req    <= ~mem_req;
                        state      <= S_SPHI;
                     end
                     default: ;
                  endcase
               end
            end
            S_SPHI: begin
               if (ack_match) begin
                  sp_q[31:16] <= mem_q;
                  sp_valid    <= 1'b1;
                  state       <= S_IDLE;
`ifdef ROM_ARB_CACHE_EN
                  if (cur_fill_ok) begin
                     sp_tag_v <= 1'b1;
                     sp_tag_a <= cur_word;
                     sp_tag_d <= {mem_q, sp_q[15:0]};
                  end
`endif
               end
            end
            default: begin
               if (ack_match) state <= S_IDLE;
            end
         endcase

`ifdef ROM_ARB_CACHE_EN
         if (cpu_hit) begin
            cpu_q     <= byte_sel(cpu_tag_d, cpu_addr_p0[0]);
            cpu_valid <= 1'b1;
         end
         if (bg_hit) begin
            bg_q     <= byte_sel(bg_tag_d, bg_addr_p0[0]);
            bg_valid <= 1'b1;
         end
         if (sp_hit) begin
            sp_q     <= sp_tag_d;
            sp_valid <= 1'b1;
         end
         // Any accepted download byte may alias a tagged word; a read already
         // in flight must not refill a tag either.
         if (dl_accept) begin
            cpu_tag_v   <= 1'b0;
            bg_tag_v    <= 1'b0;
            sp_tag_v    <= 1'b0;
            cur_fill_ok <= 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_rom_fetch_arb.sv
// Directed self-checking bench for rom_fetch_arb with a toggle-handshake SDRAM model.
module tb_rom_fetch_arb;
   localparam int AW = 23;

   logic          clk_sys, reset;
   logic          dl_wr;
   logic [24:0]   dl_addr;
   logic [7:0]    dl_dout;
   logic          dl_ovf;
   logic          cpu_rd;
   logic [15:0]   cpu_addr;
   logic [7:0]    cpu_q;
   logic          cpu_valid;
   logic          bg_rd;
   logic [13:0]   bg_addr;
   logic [7:0]    bg_q;
   logic          bg_valid;
   logic          sp_rd;
   logic [13:0]   sp_addr;
   logic [31:0]   sp_q;
   logic          sp_valid;
   logic          mem_req, mem_ack, mem_we;
   logic [AW-1:0] mem_a;
   logic [1:0]    mem_ds;
   logic [15:0]   mem_d, mem_q;

   rom_fetch_arb dut (
      .clk_sys(clk_sys), .reset(reset),
      .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_dout(dl_dout), .dl_ovf(dl_ovf),
      .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_q(cpu_q), .cpu_valid(cpu_valid),
      .bg_rd(bg_rd), .bg_addr(bg_addr), .bg_q(bg_q), .bg_valid(bg_valid),
      .sp_rd(sp_rd), .sp_addr(sp_addr), .sp_q(sp_q), .sp_valid(sp_valid),
      .mem_req(mem_req), .mem_ack(mem_ack), .mem_a(mem_a), .mem_we(mem_we),
      .mem_ds(mem_ds), .mem_d(mem_d), .mem_q(mem_q)
   );

   int vectors = 0;
   int miscompares = 0;
   int ack_dly = 2;

   logic [15:0]   mem [logic [AW-1:0]];
   logic [AW-1:0] log_a[$];
   logic          log_we[$];
   logic [1:0]    log_ds[$];
   logic [15:0]   log_d[$];

   initial begin
      clk_sys = 1'b0;
      forever #5 clk_sys = ~clk_sys;
   end

   initial begin : sdram_model
      logic          last, w;
      logic [AW-1:0] a;
      logic [1:0]    ds;
      logic [15:0]   d, rdata;
      mem_ack = 1'b0;
      mem_q   = 16'h0;
      last    = 1'b0;
      forever begin
         @(negedge clk_sys);
         if (mem_req !== last) begin
            last = mem_req;
            a = mem_a; w = mem_we; ds = mem_ds; d = mem_d;
            log_a.push_back(a); log_we.push_back(w); log_ds.push_back(ds); log_d.push_back(d);
            rdata = mem.exists(a) ? mem[a] : 16'h0;
            if (w) begin
               if (ds[0]) rdata[7:0]  = d[7:0];
               if (ds[1]) rdata[15:8] = d[15:8];
               mem[a] = rdata;
            end
            repeat (ack_dly) @(negedge clk_sys);
            mem_q   = rdata;
            mem_ack = last;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic wait_log(input int cnt, input string tag);
      int n = 0;
      while (log_a.size() < cnt && n < 200) begin
         @(negedge clk_sys);
         n++;
      end
      check(tag, log_a.size() >= cnt, 1);
   endtask

   task automatic wait_valid(input int sel, input string tag);
      int n = 0;
      logic v = 1'b0;
      while (!v && n < 100) begin
         @(negedge clk_sys);
         v = (sel == 0) ? cpu_valid : (sel == 1) ? bg_valid : sp_valid;
         n++;
      end
      check(tag, v, 1);
   endtask

   task automatic pulse_cpu(input logic [15:0] a);
      @(negedge clk_sys); cpu_rd = 1'b1; cpu_addr = a;
      @(negedge clk_sys); cpu_rd = 1'b0;
   endtask

   task automatic pulse_bg(input logic [13:0] a);
      @(negedge clk_sys); bg_rd = 1'b1; bg_addr = a;
      @(negedge clk_sys); bg_rd = 1'b0;
   endtask

   task automatic pulse_sp(input logic [13:0] a);
      @(negedge clk_sys); sp_rd = 1'b1; sp_addr = a;
      @(negedge clk_sys); sp_rd = 1'b0;
   endtask

   task automatic pulse_dl(input logic [24:0] a, input logic [7:0] d);
      @(negedge clk_sys); dl_wr = 1'b1; dl_addr = a; dl_dout = d;
      @(negedge clk_sys); dl_wr = 1'b0;
   endtask

   initial begin
      int base, n0, cnt, toggles, pulses, n;
      logic r0, r1, req0;

      reset = 1'b1;
      dl_wr = 1'b0; dl_addr = '0; dl_dout = '0;
      cpu_rd = 1'b0; cpu_addr = '0;
      bg_rd = 1'b0; bg_addr = '0;
      sp_rd = 1'b0; sp_addr = '0;
      mem[23'h008000] = 16'h00AA;
      mem[23'h00091A] = 16'hBEEF;
      mem[23'h005006] = 16'h1111;
      mem[23'h005007] = 16'h2222;
      mem[23'h00500A] = 16'h3333;
      mem[23'h00500B] = 16'h4444;
      mem[23'h008082] = 16'hA5C3;
      mem[23'h001000] = 16'h3C4D;
      mem[23'h001800] = 16'h7788;
      mem[23'h008100] = 16'h9966;
      mem[23'h002000] = 16'h0001;

      // Reset state
      tick(4);
      check("rst_valids", {cpu_valid, bg_valid, sp_valid}, 0);
      check("rst_cpu_bg_q", {cpu_q, bg_q}, 0);
      check("rst_sp_q", sp_q, 0);
      check("rst_ovf_we_ds", {dl_ovf, mem_we, mem_ds}, 0);
      check("rst_mem_a", mem_a, 0);
      check("rst_mem_d", mem_d, 0);
      check("rst_req_ack", mem_req, mem_ack);
      reset = 1'b0;
      tick(3);

      // Download byte becomes a masked word write, then read it back through BG
      pulse_dl(25'h0010001, 8'h55);
      wait_log(1, "dl1_access");
      check("dl1_mem_a", log_a[0], 23'h008000);
      check("dl1_mem_ds", log_ds[0], 2'b10);
      check("dl1_mem_d", log_d[0], 16'h5555);
      check("dl1_mem_we", log_we[0], 1);
      tick(8);
      pulse_bg(14'h0001);
      wait_valid(1, "bg1_valid");
      check("bg1_q", bg_q, 8'h55);
      check("bg1_mem_a", log_a[1], 23'h008000);
      check("bg1_rd_ctl", {log_we[1], log_ds[1]}, 3'b011);
      tick(5);

      // CPU read: request latency and single-cycle valid
      base = log_a.size();
      @(negedge clk_sys); cpu_rd = 1'b1; cpu_addr = 16'h1235; r0 = mem_req;
      @(posedge clk_sys); #1;
      cpu_rd = 1'b0;
      @(posedge clk_sys); #1;
      check("cpu_req_n1", mem_req, r0);
      @(posedge clk_sys); #1;
      r1 = ~r0;
      check("cpu_req_n2", mem_req, r1);
      wait_valid(0, "cpu2_valid");
      check("cpu2_q", cpu_q, 8'hBE);
      @(negedge clk_sys);
      check("cpu2_valid_1cyc", cpu_valid, 0);
      check("cpu2_mem_a", log_a[base], 23'h00091A);
      tick(5);

      // Sprite: two word fetches, one valid pulse
      base = log_a.size();
      pulse_sp(14'd3);
      cnt = 0;
      repeat (40) begin
         @(negedge clk_sys);
         if (sp_valid) cnt++;
      end
      check("sp3_pulses", cnt, 1);
      check("sp3_q", sp_q, 32'h2222_1111);
      check("sp3_lo_addr", log_a[base], 23'h005006);
      check("sp3_hi_addr", log_a[base+1], 23'h005007);

      // Simultaneous strobes: priority order
      ack_dly = 6;
      base = log_a.size();
      @(negedge clk_sys);
      dl_wr = 1'b1; dl_addr = 25'h0000004; dl_dout = 8'h77;
      sp_rd = 1'b1; sp_addr = 14'd5;
      bg_rd = 1'b1; bg_addr = 14'h0104;
      cpu_rd = 1'b1; cpu_addr = 16'h2000;
      @(negedge clk_sys);
      dl_wr = 1'b0; sp_rd = 1'b0; bg_rd = 1'b0; cpu_rd = 1'b0;
      wait_log(base + 5, "sim_accesses");
      tick(20);
      check("sim_0_dl", {log_we[base], log_a[base]}, {1'b1, 23'h000002});
      check("sim_0_ds_d", {log_ds[base], log_d[base]}, {2'b01, 16'h7777});
      check("sim_1_sp_lo", log_a[base+1], 23'h00500A);
      check("sim_2_sp_hi", log_a[base+2], 23'h00500B);
      check("sim_3_bg", log_a[base+3], 23'h008082);
      check("sim_4_cpu", log_a[base+4], 23'h001000);
      check("sim_sp_q", sp_q, 32'h4444_3333);
      check("sim_bg_q", bg_q, 8'hC3);
      check("sim_cpu_q", cpu_q, 8'h4D);
      check("sim_no_ovf", dl_ovf, 0);

      // Overflow: second byte while the one-entry buffer is still full
      ack_dly = 8;
      base = log_a.size();
      pulse_cpu(16'h4000);
      wait_log(base + 1, "ovf_cpu_access");
      pulse_dl(25'h0000040, 8'h12);
      tick(1);
      check("ovf_before", dl_ovf, 0);
      pulse_dl(25'h0000042, 8'h34);
      tick(2);
      check("ovf_after", dl_ovf, 1);
      wait_log(base + 2, "ovf_dl_access");
      tick(40);
      check("ovf_access_count", log_a.size(), base + 2);
      check("ovf_dl_a", log_a[base+1], 23'h000020);
      check("ovf_dl_ds_d", {log_ds[base+1], log_d[base+1]}, {2'b01, 16'h1212});
      check("ovf_cpu_q", cpu_q, 8'h01);

      // Reset while an access is in flight: drain before new traffic
      ack_dly = 5;
      base = log_a.size();
      pulse_cpu(16'h3000);
      wait_log(base + 1, "drain_cpu_access");
      @(negedge clk_sys); reset = 1'b1;
      @(negedge clk_sys); reset = 1'b0; bg_rd = 1'b1; bg_addr = 14'h0200;
      check("drain_rst_ovf", dl_ovf, 0);
      check("drain_rst_cpu_q", cpu_q, 0);
      req0 = mem_req;
      toggles = 0; pulses = 0; n = 0;
      while (mem_ack !== req0 && n < 30) begin
         @(negedge clk_sys);
         bg_rd = 1'b0;
         n++;
         if (mem_req !== req0) toggles++;
         pulses += int'(cpu_valid) + int'(bg_valid) + int'(sp_valid);
      end
      bg_rd = 1'b0;
      check("drain_ack_seen", mem_ack, req0);
      check("drain_no_toggle", toggles, 0);
      check("drain_no_valid", pulses, 0);
      wait_valid(1, "drain_bg_valid");
      check("drain_bg_q", bg_q, 8'h66);
      check("drain_bg_a", log_a[base+1], 23'h008100);
      check("drain_cpu_q_kept", cpu_q, 0);
      ack_dly = 2;
      tick(5);

      // Repeated BG read of one word, then after a download
      pulse_bg(14'h0104);
      wait_valid(1, "rep1_bg_valid");
      check("rep1_bg_q", bg_q, 8'hC3);
      tick(5);
      n0 = log_a.size();
`ifdef ROM_ARB_CACHE_EN
      @(negedge clk_sys); bg_rd = 1'b1; bg_addr = 14'h0104;
      @(posedge clk_sys); #1;
      bg_rd = 1'b0;
      @(posedge clk_sys); #1;
      check("hit_valid_n1", bg_valid, 1);
      check("hit_q", bg_q, 8'hC3);
      tick(10);
      check("hit_no_access", log_a.size(), n0);
      pulse_dl(25'h0000060, 8'h33);
      wait_log(n0 + 1, "inv_dl_access");
      tick(5);
      pulse_bg(14'h0104);
      wait_valid(1, "inv_bg_valid");
      check("inv_access_count", log_a.size(), n0 + 2);
      check("inv_bg_a", log_a[n0+1], 23'h008082);
      check("inv_bg_q", bg_q, 8'hC3);
`else
      pulse_bg(14'h0104);
      wait_valid(1, "rep2_bg_valid");
      check("rep2_access_count", log_a.size(), n0 + 1);
      check("rep2_bg_a", log_a[n0], 23'h008082);
      check("rep2_bg_q", bg_q, 8'hC3);
`endif
      tick(5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
